// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong ball controller: FSM states,
// bounce command encoding and default screen geometry.
package pong_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StScored,
        StOver
    } state_t;

    localparam logic [1:0] BOUNCE_NONE   = 2'b00;
    localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0] BOUNCE_WALL   = 2'b10;
    localparam logic [1:0] BOUNCE_SERVE  = 2'b11;

    localparam int unsigned SCREEN_X = 640;
    localparam int unsigned SCREEN_Y = 480;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational geometry check of the ball against walls, both paddles and goal lines.
// All sums are 11 bits wide so edge coordinates never wrap.
module ball_collide
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_X = pong_pkg::SCREEN_X,
    parameter int unsigned SCREEN_Y = pong_pkg::SCREEN_Y,
    parameter int unsigned PAD_L_X  = 16,
    parameter int unsigned PAD_R_X  = 616,
    parameter int unsigned PAD_W    = 8,
    parameter int unsigned PAD_H    = 64
) (
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_w,
    input  logic [7:0] ball_h,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    output logic       hit_pad,
    output logic       hit_wall,
    output logic       goal_l,
    output logic       goal_r
);

    localparam logic [10:0] PadLLeft  = 11'(PAD_L_X);
    localparam logic [10:0] PadLRight = 11'(PAD_L_X + PAD_W);
    localparam logic [10:0] PadRLeft  = 11'(PAD_R_X);
    localparam logic [10:0] PadRRight = 11'(PAD_R_X + PAD_W);
    localparam logic [10:0] PadH      = 11'(PAD_H);
    localparam logic [10:0] ScreenX   = 11'(SCREEN_X);
    localparam logic [10:0] ScreenY   = 11'(SCREEN_Y);

    logic [10:0] x0, x1, y0, y1, pl_top, pr_top;
    logic        ovl_l, ovl_r, hit_l, hit_r;

    assign x0     = {1'b0, ball_x};
    assign y0     = {1'b0, ball_y};
    assign x1     = x0 + {3'b000, ball_w};
    assign y1     = y0 + {3'b000, ball_h};
    assign pl_top = {1'b0, pad_l_y};
    assign pr_top = {1'b0, pad_r_y};

    assign ovl_l = (y0 < pl_top + PadH) && (y1 > pl_top);
    assign ovl_r = (y0 < pr_top + PadH) && (y1 > pr_top);

    assign hit_l = (x0 <= PadLRight) && (x1 > PadLLeft) && ovl_l;
    assign hit_r = (x1 >= PadRLeft) && (x0 < PadRRight) && ovl_r;

    assign hit_pad  = hit_l || hit_r;
    assign hit_wall = (y0 == 11'd0) || (y1 >= ScreenY);
    assign goal_l   = (x0 == 11'd0);
    assign goal_r   = (x1 >= ScreenX);

endmodule

// File: rtl/pong_ball_ctrl.sv
// Game-level Pong controller: serve/play/scored/over flow, per-frame collision
// commands, move pacing and scores. Optional macro SPEEDUP_EN enables rally speed-up.
module pong_ball_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_X     = pong_pkg::SCREEN_X,
    parameter int unsigned SCREEN_Y     = pong_pkg::SCREEN_Y,
    parameter int unsigned PAD_L_X      = 16,
    parameter int unsigned PAD_R_X      = 616,
    parameter int unsigned PAD_W        = 8,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_w,
    input  logic [7:0] ball_h,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    output logic [1:0] bounce,
    output logic       move_en,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned SERVE_W = $clog2(SERVE_FRAMES + 1);

    state_t               state_q, state_d;
    logic [1:0]           bounce_q, bounce_d;
    logic                 move_en_q, move_en_d;
    logic [3:0]           score_l_q, score_l_d, score_r_q, score_r_d;
    logic                 game_over_q, game_over_d;
    logic                 winner_q, winner_d;
    logic [3:0]           div_q, div_d;
    logic [SERVE_W-1:0]   serve_q, serve_d;
    logic [1:0]           cool_q, cool_d;
    logic                 enter_serve;
    logic                 hit_pad, hit_wall, goal_l, goal_r;
    logic [3:0]           limit;

`ifdef SPEEDUP_EN
    logic [3:0] limit_q, limit_d;
    logic [1:0] rally_q, rally_d;
    assign limit = limit_q;
`else
    assign limit = 4'(SPEED);
`endif

    ball_collide #(
        .SCREEN_X (SCREEN_X),
        .SCREEN_Y (SCREEN_Y),
        .PAD_L_X  (PAD_L_X),
        .PAD_R_X  (PAD_R_X),
        .PAD_W    (PAD_W),
        .PAD_H    (PAD_H)
    ) u_collide (
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .ball_w   (ball_w),
        .ball_h   (ball_h),
        .pad_l_y  (pad_l_y),
        .pad_r_y  (pad_r_y),
        .hit_pad  (hit_pad),
        .hit_wall (hit_wall),
        .goal_l   (goal_l),
        .goal_r   (goal_r)
    );

    always_comb begin
        state_d     = state_q;
        bounce_d    = BOUNCE_NONE;
        move_en_d   = 1'b0;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        div_d       = div_q;
        serve_d     = serve_q;
        cool_d      = cool_q;
        enter_serve = 1'b0;
`ifdef SPEEDUP_EN
        limit_d     = limit_q;
        rally_d     = rally_q;
`endif

        unique case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d     = StServe;
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    enter_serve = 1'b1;
                end
            end
            StServe: begin
                if (frame_tick) begin
                    if (serve_q == SERVE_W'(SERVE_FRAMES - 1)) begin
                        state_d = StPlay;
                        serve_d = '0;
                    end else begin
                        serve_d = serve_q + 1'b1;
                    end
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    if (cool_q != 2'd0) cool_d = cool_q - 2'd1;
                    // >= so a limit that just shrank below the running count still fires
                    if (div_q >= limit - 4'd1) begin
                        move_en_d = 1'b1;
                        div_d     = 4'd0;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                    if (goal_l) begin
                        score_r_d = sat_inc(score_r_q);
                        winner_d  = 1'b1;
                        state_d   = StScored;
                    end else if (goal_r) begin
                        score_l_d = sat_inc(score_l_q);
                        winner_d  = 1'b0;
                        state_d   = StScored;
                    end else if (cool_q == 2'd0) begin
                        if (hit_pad) begin
                            bounce_d = BOUNCE_PADDLE;
                            cool_d   = 2'd2;
`ifdef SPEEDUP_EN
                            rally_d  = rally_q + 2'd1;
                            if (rally_q == 2'd3 && limit_q > 4'd1) limit_d = limit_q - 4'd1;
`endif
                        end else if (hit_wall) begin
                            bounce_d = BOUNCE_WALL;
                            cool_d   = 2'd2;
                        end
                    end
                end
            end
            StScored: begin
                if (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) begin
                    state_d = StOver;
                end else begin
                    state_d     = StServe;
                    enter_serve = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_serve) begin
            bounce_d = BOUNCE_SERVE;
            serve_d  = '0;
            div_d    = 4'd0;
            cool_d   = 2'd0;
`ifdef SPEEDUP_EN
            limit_d  = 4'(SPEED);
            rally_d  = 2'd0;
`endif
        end

        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bounce_q    <= BOUNCE_NONE;
            move_en_q   <= 1'b0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            div_q       <= 4'd0;
            serve_q     <= '0;
            cool_q      <= 2'd0;
`ifdef SPEEDUP_EN
            limit_q     <= 4'(SPEED);
            rally_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            bounce_q    <= bounce_d;
            move_en_q   <= move_en_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            div_q       <= div_d;
            serve_q     <= serve_d;
            cool_q      <= cool_d;
`ifdef SPEEDUP_EN
            limit_q     <= limit_d;
            rally_q     <= rally_d;
`endif
        end
    end

    assign bounce    = bounce_q;
    assign move_en   = move_en_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: collision vector table plus hand-written
// serve, cooldown, scoring, game-over and mid-frame reset sequences.
module tb_pong_ball_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic [7:0] ball_w, ball_h;
    logic [1:0] bounce;
    logic       move_en;
    logic [3:0] score_l, score_r;
    logic       game_over, winner;

    int tests = 0;
    int fails = 0;
    int play_ticks = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] w;
        logic [7:0] h;
        logic [9:0] pl;
        logic [9:0] pr;
        logic [1:0] exp_b;
    } vec_t;

    vec_t vecs[14];

    pong_ball_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .ball_w    (ball_w),
        .ball_h    (ball_h),
        .pad_l_y   (pad_l_y),
        .pad_r_y   (pad_r_y),
        .bounce    (bounce),
        .move_en   (move_en),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_ball(input logic [9:0] x, input logic [9:0] y, input logic [7:0] w,
                            input logic [7:0] h, input logic [9:0] pl, input logic [9:0] pr);
        ball_x = x; ball_y = y; ball_w = w; ball_h = h; pad_l_y = pl; pad_r_y = pr;
    endtask

    task automatic neutral();
        set_ball(10'd300, 10'd200, 8'd10, 8'd10, 10'd200, 10'd200);
    endtask

    // Outputs of the tick edge are visible at the negedge where this returns
    task automatic pulse();
        @(negedge clock) frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic play_tick(input logic [1:0] exp_b, input bit chk_mv, input string nm);
        pulse();
        play_ticks++;
        check({nm, "_bounce"}, bounce, exp_b);
        if (chk_mv) check({nm, "_move_en"}, move_en, (play_ticks % 2 == 0));
    endtask

    task automatic serve_wait(input string nm);
        int noisy;
        noisy = 0;
        repeat (60) begin
            pulse();
            if (move_en !== 1'b0 || bounce !== 2'b00) noisy++;
        end
        check({nm, "_serve_quiet"}, noisy, 0);
        play_ticks = 0;
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_bounce"}, bounce, 2'b00);
        check({nm, "_move_en"}, move_en, 1'b0);
        check({nm, "_score_l"}, score_l, 4'd0);
        check({nm, "_score_r"}, score_r, 4'd0);
        check({nm, "_game_over"}, game_over, 1'b0);
        check({nm, "_winner"}, winner, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{10'd300, 10'd0,   8'd10, 8'd10, 10'd200, 10'd200, 2'b10};
        vecs[1]  = '{10'd300, 10'd470, 8'd10, 8'd10, 10'd200, 10'd200, 2'b10};
        vecs[2]  = '{10'd300, 10'd469, 8'd10, 8'd10, 10'd200, 10'd200, 2'b00};
        vecs[3]  = '{10'd20,  10'd220, 8'd30, 8'd30, 10'd200, 10'd200, 2'b01};
        vecs[4]  = '{10'd20,  10'd300, 8'd30, 8'd30, 10'd200, 10'd200, 2'b00};
        vecs[5]  = '{10'd24,  10'd220, 8'd10, 8'd10, 10'd200, 10'd200, 2'b01};
        vecs[6]  = '{10'd25,  10'd220, 8'd10, 8'd10, 10'd200, 10'd200, 2'b00};
        vecs[7]  = '{10'd600, 10'd150, 8'd16, 8'd10, 10'd200, 10'd100, 2'b01};
        vecs[8]  = '{10'd599, 10'd150, 8'd16, 8'd10, 10'd200, 10'd100, 2'b00};
        vecs[9]  = '{10'd600, 10'd164, 8'd16, 8'd10, 10'd200, 10'd100, 2'b00};
        vecs[10] = '{10'd600, 10'd90,  8'd16, 8'd11, 10'd200, 10'd100, 2'b01};
        vecs[11] = '{10'd600, 10'd90,  8'd16, 8'd10, 10'd200, 10'd100, 2'b00};
        vecs[12] = '{10'd20,  10'd0,   8'd10, 8'd10, 10'd0,   10'd200, 2'b01};
        vecs[13] = '{10'd6,   10'd220, 8'd10, 8'd10, 10'd200, 10'd200, 2'b00};

        neutral();
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;

        // Ticks in IDLE do nothing
        pulse();
        check("idle_tick_move_en", move_en, 1'b0);
        check("idle_tick_bounce", bounce, 2'b00);

        pulse_start();
        check("start_serve_bounce", bounce, 2'b11);
        @(negedge clock);
        check("serve_bounce_one_cycle", bounce, 2'b00);
        serve_wait("first");

        for (int i = 0; i < 14; i++) begin
            set_ball(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].pl, vecs[i].pr);
            play_tick(vecs[i].exp_b, 1'b1, $sformatf("vec%0d", i));
            neutral();
            play_tick(2'b00, 1'b1, $sformatf("vec%0d_drain1", i));
            play_tick(2'b00, 1'b1, $sformatf("vec%0d_drain2", i));
        end

        // Cooldown: ball stays on the wall for several frames
        set_ball(10'd300, 10'd0, 8'd10, 8'd10, 10'd200, 10'd200);
        play_tick(2'b10, 1'b1, "cool_first");
        play_tick(2'b00, 1'b1, "cool_sup1");
        play_tick(2'b00, 1'b1, "cool_sup2");
        play_tick(2'b10, 1'b1, "cool_again");

        // Left goal during cooldown still scores for the right player
        set_ball(10'd0, 10'd200, 8'd10, 8'd10, 10'd200, 10'd200);
        play_tick(2'b00, 1'b0, "goal_left");
        check("goal_left_score_r", score_r, 4'd1);
        check("goal_left_winner", winner, 1'b1);
        neutral();
        @(negedge clock);
        check("rethrow_bounce", bounce, 2'b11);
        check("rethrow_game_over", game_over, 1'b0);
        serve_wait("after_goal_l");

        for (int i = 1; i <= 9; i++) begin
            set_ball(10'd615, 10'd300, 8'd30, 8'd10, 10'd200, 10'd0);
            play_tick(2'b00, 1'b0, $sformatf("goal_r%0d", i));
            check($sformatf("goal_r%0d_score_l", i), score_l, i);
            neutral();
            @(negedge clock);
            if (i < 9) begin
                check($sformatf("goal_r%0d_rethrow", i), bounce, 2'b11);
                serve_wait($sformatf("goal_r%0d", i));
            end else begin
                check("over_game_over", game_over, 1'b1);
                check("over_winner", winner, 1'b0);
                check("over_score_l", score_l, 4'd9);
                check("over_score_r", score_r, 4'd1);
            end
        end

        pulse();
        check("over_tick_ignored", move_en, 1'b0);
        check("over_still_over", game_over, 1'b1);

        pulse_start();
        check("restart_bounce", bounce, 2'b11);
        check("restart_score_l", score_l, 4'd0);
        check("restart_score_r", score_r, 4'd0);
        check("restart_game_over", game_over, 1'b0);
        pulse_start();
        check("start_in_serve_ignored", bounce, 2'b00);
        serve_wait("restart");

        set_ball(10'd0, 10'd200, 8'd10, 8'd10, 10'd200, 10'd200);
        play_tick(2'b00, 1'b0, "pre_reset_goal");
        check("pre_reset_score_r", score_r, 4'd1);
        neutral();
        @(negedge clock);
        serve_wait("pre_reset");

        // Reset lands on the edge that would have produced a wall bounce
        set_ball(10'd300, 10'd0, 8'd10, 8'd10, 10'd200, 10'd200);
        @(negedge clock) frame_tick = 1'b1;
        #2 reset = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
        check_reset_vals("mid_reset");
        @(negedge clock);
        check("mid_reset_hold_bounce", bounce, 2'b00);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
